// File: rtl/mem_stage_pkg.sv
// Opcodes, FSM encodings and register indices shared by the memory stage
// and anything that talks to it.
package mem_stage_pkg;

    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_LD   = 8'h10;
    localparam logic [7:0] OPC_ST   = 8'h11;
    localparam logic [7:0] OPC_PUSH = 8'h12;
    localparam logic [7:0] OPC_POP  = 8'h13;
    localparam logic [7:0] OPC_JMP  = 8'h20;

    localparam logic [2:0] REG_SP = 3'd7;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_REQ  = 2'd1,
        MEM_STATE_WB   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        mem_req;
        logic        mem_we;
        logic        wb_en;
        logic [2:0]  wb_sel;
        logic [15:0] wb_data;
        logic        sp_wb_en;
        logic [15:0] sp_wb_data;
        logic        pc_load;
        logic [15:0] pc_value;
        logic        done;
        logic        bus_error;
    } mem_out_t;

    function automatic logic is_mem_op(input logic [7:0] opc);
        return (opc == OPC_LD) || (opc == OPC_ST) || (opc == OPC_PUSH) || (opc == OPC_POP);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: one instruction in flight, req/ack bus access, register/SP
// writeback and branch redirect. Every output is registered.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [2:0]  SP_REG      = REG_SP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  alu_control,
    input  logic [15:0] alu_out,
    input  logic [15:0] st_data,
    input  logic        write_in,
    input  logic        should_branch,
    input  logic [15:0] sp_in,
    input  logic [2:0]  rd_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [2:0]  wb_sel,
    output logic [15:0] wb_data,
    output logic        sp_wb_en,
    output logic [15:0] sp_wb_data,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        busy,
    output logic        done,
    output logic        bus_error
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    mem_out_t    out_q, out_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  op_q, op_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] rdata_q, rdata_d;
    logic        accept_mem;
    logic        timeout_hit;

    assign accept_mem  = en && is_mem_op(alu_control) && !alu_out[0];
    // An ack in the expiry cycle is checked first, so it wins over the timeout.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_STATE_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            sp_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            sp_q    <= sp_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_STATE_IDLE: if (accept_mem) state_d = MEM_STATE_REQ;
            MEM_STATE_REQ: begin
                if (mem_ack)          state_d = MEM_STATE_WB;
                else if (timeout_hit) state_d = MEM_STATE_IDLE;
            end
            MEM_STATE_WB:   state_d = MEM_STATE_IDLE;
            default:        state_d = MEM_STATE_IDLE;
        endcase
    end

    always_comb begin
        out_d           = out_q;
        out_d.wb_en     = 1'b0;
        out_d.sp_wb_en  = 1'b0;
        out_d.pc_load   = 1'b0;
        out_d.done      = 1'b0;
        out_d.bus_error = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        sp_d    = sp_q;
        rdata_d = rdata_q;
        case (state_q)
            MEM_STATE_IDLE: begin
                if (en) begin
                    if (is_mem_op(alu_control)) begin
                        if (alu_out[0]) begin
                            out_d.bus_error = 1'b1;
                            out_d.done      = 1'b1;
                        end else begin
                            out_d.mem_req   = 1'b1;
                            out_d.mem_addr  = alu_out;
                            out_d.mem_we    = (alu_control == OPC_ST) || (alu_control == OPC_PUSH);
                            out_d.mem_wdata = st_data;
                            op_d  = alu_control;
                            rd_d  = rd_sel;
                            sp_d  = sp_in;
                            cnt_d = '0;
                        end
                    end else if (alu_control == OPC_JMP) begin
                        out_d.pc_load  = should_branch;
                        out_d.pc_value = alu_out;
                        out_d.done     = 1'b1;
                    end else begin
                        out_d.wb_en   = write_in;
                        out_d.wb_sel  = rd_sel;
                        out_d.wb_data = alu_out;
                        out_d.done    = 1'b1;
                    end
                end
            end
            MEM_STATE_REQ: begin
                if (mem_ack) begin
                    out_d.mem_req = 1'b0;
                    rdata_d       = mem_rdata;
                end else if (timeout_hit) begin
                    out_d.mem_req   = 1'b0;
                    out_d.bus_error = 1'b1;
                    out_d.done      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MEM_STATE_WB: begin
                out_d.done = 1'b1;
                case (op_q)
                    OPC_LD: begin
                        out_d.wb_en   = 1'b1;
                        out_d.wb_sel  = rd_q;
                        out_d.wb_data = rdata_q;
                    end
                    OPC_POP: begin
                        out_d.sp_wb_en   = 1'b1;
                        out_d.sp_wb_data = sp_q;
                        // Popping into SP itself: the SP update owns the register.
                        if (rd_q != SP_REG) begin
                            out_d.wb_en   = 1'b1;
                            out_d.wb_sel  = rd_q;
                            out_d.wb_data = rdata_q;
                        end
                    end
                    OPC_PUSH: begin
                        out_d.sp_wb_en   = 1'b1;
                        out_d.sp_wb_data = sp_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_addr   = out_q.mem_addr;
    assign mem_wdata  = out_q.mem_wdata;
    assign mem_req    = out_q.mem_req;
    assign mem_we     = out_q.mem_we;
    assign wb_en      = out_q.wb_en;
    assign wb_sel     = out_q.wb_sel;
    assign wb_data    = out_q.wb_data;
    assign sp_wb_en   = out_q.sp_wb_en;
    assign sp_wb_data = out_q.sp_wb_data;
    assign pc_load    = out_q.pc_load;
    assign pc_value   = out_q.pc_value;
    assign done       = out_q.done;
    assign bus_error  = out_q.bus_error;
    assign busy       = (state_q != MEM_STATE_IDLE);

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized transactions against a transaction-level model of
// the memory stage's expected outcome per instruction.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  alu_control = '0;
    logic [15:0] alu_out = '0, st_data = '0, sp_in = '0, mem_rdata = '0;
    logic        write_in = 1'b0, should_branch = 1'b0, mem_ack = 1'b0;
    logic [2:0]  rd_sel = '0;
    logic [15:0] mem_addr, mem_wdata, wb_data, sp_wb_data, pc_value;
    logic        mem_req, mem_we, wb_en, sp_wb_en, pc_load, busy, done, bus_error;
    logic [2:0]  wb_sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(TO), .SP_REG(REG_SP)) dut (
        .clk(clk), .rst(rst), .en(en), .alu_control(alu_control), .alu_out(alu_out),
        .st_data(st_data), .write_in(write_in), .should_branch(should_branch),
        .sp_in(sp_in), .rd_sel(rd_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .sp_wb_en(sp_wb_en),
        .sp_wb_data(sp_wb_data), .pc_load(pc_load), .pc_value(pc_value),
        .busy(busy), .done(done), .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle after a completion: every strobe must be gone; a stray ack is ignored.
    task automatic idle_check();
        @(posedge clk); #1;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle.strobes", {done, wb_en, sp_wb_en, pc_load, bus_error}, 0);
        chk("idle.busy", busy, 0);
        chk("idle.req", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle.stray_ack", {done, wb_en, sp_wb_en, busy}, 0);
    endtask

    // One instruction. waitc = no-ack REQ cycles before ack; waitc >= TO means never ack.
    task automatic txn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] sd,
                       input logic [15:0] sp, input logic wr, input logic br,
                       input logic [2:0] rd, input int waitc);
        bit          is_mem = (op == OPC_LD) || (op == OPC_ST) || (op == OPC_PUSH) || (op == OPC_POP);
        bit          acked  = (waitc < TO);
        int          nreq   = acked ? waitc + 1 : TO;
        logic [15:0] rdv    = 16'($urandom);
        bit          exp_wb, exp_sp;
        @(posedge clk); #1;
        en = 1'b1; alu_control = op; alu_out = a; st_data = sd; sp_in = sp;
        write_in = wr; should_branch = br; rd_sel = rd;
        @(posedge clk); #1;
        en = 1'b0; alu_out = 16'($urandom); st_data = 16'($urandom);
        sp_in = 16'($urandom); rd_sel = 3'($urandom);
        if (!is_mem) begin
            @(negedge clk);
            chk("nm.done", done, 1);
            chk("nm.busy", busy, 0);
            chk("nm.req", mem_req, 0);
            if (op == OPC_JMP) begin
                chk("jmp.pc_load", pc_load, br);
                if (br) chk("jmp.pc_value", pc_value, a);
                chk("jmp.wb_en", wb_en, 0);
            end else begin
                chk("alu.wb_en", wb_en, wr);
                if (wr) begin
                    chk("alu.wb_sel", wb_sel, rd);
                    chk("alu.wb_data", wb_data, a);
                end
                chk("alu.pc_load", pc_load, 0);
            end
        end else if (a[0]) begin
            @(negedge clk);
            chk("mis.bus_error", bus_error, 1);
            chk("mis.done", done, 1);
            chk("mis.req", mem_req, 0);
            chk("mis.wb", {wb_en, sp_wb_en, busy}, 0);
        end else begin
            for (int i = 0; i < nreq; i++) begin
                @(negedge clk);
                chk("req.req", mem_req, 1);
                chk("req.addr", mem_addr, a);
                chk("req.we", mem_we, (op == OPC_ST) || (op == OPC_PUSH));
                chk("req.wdata", mem_wdata, sd);
                chk("req.busy_done", {busy, done}, 2'b10);
                if (acked && i == waitc) begin
                    mem_ack = 1'b1; mem_rdata = rdv;
                end
                if ($urandom_range(0, 3) == 0) begin
                    en = 1'b1; alu_control = OPC_ADD; write_in = 1'b1;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0; en = 1'b0; mem_rdata = 16'($urandom);
            end
            @(negedge clk);
            if (acked) begin
                chk("wbs.req", mem_req, 0);
                chk("wbs.busy_done", {busy, done}, 2'b10);
                @(posedge clk); #1;
                @(negedge clk);
                exp_wb = (op == OPC_LD) || (op == OPC_POP && rd != REG_SP);
                exp_sp = (op == OPC_PUSH) || (op == OPC_POP);
                chk("wb.done", done, 1);
                chk("wb.busy", busy, 0);
                chk("wb.bus_error", bus_error, 0);
                chk("wb.wb_en", wb_en, exp_wb);
                if (exp_wb) begin
                    chk("wb.wb_sel", wb_sel, rd);
                    chk("wb.wb_data", wb_data, rdv);
                end
                chk("wb.sp_wb_en", sp_wb_en, exp_sp);
                if (exp_sp) chk("wb.sp_wb_data", sp_wb_data, sp);
            end else begin
                chk("to.req", mem_req, 0);
                chk("to.bus_error", bus_error, 1);
                chk("to.done", done, 1);
                chk("to.nowb", {wb_en, sp_wb_en, busy}, 0);
            end
        end
        idle_check();
    endtask

    initial begin
        logic [7:0]  rop;
        logic [15:0] ra;
        int          rw;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.strobes", {done, wb_en, sp_wb_en, pc_load, bus_error, mem_req, busy}, 0);
        chk("rst.data", {mem_addr, mem_wdata, wb_data, sp_wb_data}, 0);
        chk("rst.misc", {pc_value, mem_we, wb_sel}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        txn(OPC_ADD,  16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd3, 0);
        txn(OPC_LD,   16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd2, 2);
        txn(OPC_PUSH, 16'h0FFE, 16'h55AA, 16'h0FFE, 1'b0, 1'b0, 3'd0, 0);
        txn(OPC_ST,   16'h0021, 16'h1111, 16'h0000, 1'b0, 1'b0, 3'd0, 0);
        txn(OPC_LD,   16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd1, TO);
        txn(OPC_JMP,  16'h0200, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd4, 0);
        txn(OPC_JMP,  16'h0300, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd4, 0);
        txn(OPC_POP,  16'h0F00, 16'h0000, 16'h0F02, 1'b1, 1'b0, 3'd5, 1);
        txn(OPC_POP,  16'h0F02, 16'h0000, 16'h0F04, 1'b1, 1'b0, REG_SP, 0);
        txn(OPC_LD,   16'h0042, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd6, TO - 1);
        txn(OPC_ST,   16'h0044, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 3'd0, 3);

        // Reset in the middle of a request: mem_req drops at that edge, nothing completes.
        @(posedge clk); #1;
        en = 1'b1; alu_control = OPC_LD; alu_out = 16'h0100; rd_sel = 3'd2;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstx.req_before", mem_req, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstx.req", mem_req, 0);
        chk("rstx.strobes", {busy, done, wb_en, sp_wb_en, bus_error}, 0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstx.late_ack", {busy, done, wb_en, sp_wb_en, bus_error, mem_req}, 0);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 5))
                0:       rop = OPC_ADD;
                1:       rop = OPC_LD;
                2:       rop = OPC_ST;
                3:       rop = OPC_PUSH;
                4:       rop = OPC_POP;
                default: rop = OPC_JMP;
            endcase
            ra = 16'($urandom);
            if ($urandom_range(0, 4) != 0) ra[0] = 1'b0;
            rw = $urandom_range(0, 9);
            if (rw == 6)      rw = TO - 1;
            else if (rw == 7) rw = TO;
            else if (rw > 7)  rw = $urandom_range(0, 3);
            txn(rop, ra, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
